// File: rtl/seq_alu_core.sv
// ---------------------------------------------------------------------------
// seq_alu_core
//   Registered, parametrised ALU with a valid/ready handshake on both sides.
//   Single-cycle ops (add/sub/shift/rotate/logic/compare) complete at the
//   accept edge. MUL is an iterative shift-add and DIV an iterative restoring
//   divide, each taking WIDTH extra cycles. Results and flags are held stable
//   while out_valid is high, until downstream takes them.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands/op presented        in_ready   core is idle
//   a, b         WIDTH-bit operands           alu_select 4-bit op code
//   out_valid    result/flags valid           out_ready  downstream accepts
//   alu_out      result (MUL low word, DIV quotient)
//   res_hi       MUL high word, DIV remainder, otherwise 0
//   carry_out    add carry / sub borrow / shifted-out bit / MUL high nonzero
//   zero         alu_out == 0
//   overflow     signed overflow of ADD/SUB
//   div_by_zero  DIV with b == 0
// ---------------------------------------------------------------------------
module seq_alu_core #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] res_hi,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state, state_next;
    logic             accept;
    logic             step_last;
    logic [CNT_W-1:0] count;

    // Iteration registers: hi_reg is the partial product high word (MUL) or
    // the partial remainder (DIV); lo_reg holds the multiplier bits being
    // consumed (MUL) or the dividend shifting into the quotient (DIV).
    logic [WIDTH-1:0] hi_reg, lo_reg, b_reg;

    // Single-cycle result path, computed straight from the live inputs so it
    // can be registered on the accept edge.
    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] fast_lo, fast_hi;
    logic             fast_c, fast_ov, fast_dz;

    // One MUL / DIV iteration.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_fits;
    logic [WIDTH-1:0] div_hi_next, div_lo_next;

    assign accept    = in_valid && in_ready;
    assign step_last = (count == CNT_W'(WIDTH - 1));

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};

    always_comb begin
        fast_lo = '0;
        fast_hi = '0;
        fast_c  = 1'b0;
        fast_ov = 1'b0;
        fast_dz = 1'b0;
        case (alu_select)
            4'h0: begin
                fast_lo = add_full[WIDTH-1:0];
                fast_c  = add_full[WIDTH];
                fast_ov = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            4'h1: begin
                fast_lo = sub_full[WIDTH-1:0];
                fast_c  = sub_full[WIDTH];        // borrow, i.e. a < b
                fast_ov = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            4'h3: begin
                // Only the divide-by-zero case finishes here; a real divide
                // iterates and writes its own result.
                if (b == '0) begin
                    fast_lo = '1;
                    fast_hi = a;
                    fast_dz = 1'b1;
                end
            end
            4'h4: begin fast_lo = {a[WIDTH-2:0], 1'b0};       fast_c = a[WIDTH-1]; end
            4'h5: begin fast_lo = {1'b0, a[WIDTH-1:1]};       fast_c = a[0];       end
            4'h6: begin fast_lo = {a[WIDTH-2:0], a[WIDTH-1]}; fast_c = a[WIDTH-1]; end
            4'h7: begin fast_lo = {a[0], a[WIDTH-1:1]};       fast_c = a[0];       end
            4'h8: fast_lo = a & b;
            4'h9: fast_lo = a | b;
            4'hA: fast_lo = a ^ b;
            4'hB: fast_lo = ~(a | b);
            4'hC: fast_lo = ~(a & b);
            4'hD: fast_lo = ~(a ^ b);
            4'hE: fast_lo = WIDTH'(a > b);
            4'hF: fast_lo = WIDTH'(a == b);
            default: ;                            // MUL: handled iteratively
        endcase
    end

    // Shift-add: add the multiplicand when the current multiplier bit is set,
    // then shift the double-width {hi,lo} right one place.
    assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    assign mul_hi_next = mul_sum[WIDTH:1];
    assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor only if it fits. The shifted remainder is always
    // below 2*b, so the difference fits back into WIDTH bits.
    assign div_shift   = {hi_reg, lo_reg[WIDTH-1]};
    assign div_fits    = (div_shift >= {1'b0, b_reg});
    assign div_diff    = WIDTH'(div_shift - {1'b0, b_reg});
    assign div_hi_next = div_fits ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_next = {lo_reg[WIDTH-2:0], div_fits};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (alu_select == 4'h2)                   state_next = S_MUL;
                    else if (alu_select == 4'h3 && b != '0)   state_next = S_DIV;
                    else                                      state_next = S_DONE;
                end
            end
            S_MUL, S_DIV: if (step_last) state_next = S_DONE;
            S_DONE:       if (out_ready) state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg      <= '0;
            lo_reg      <= '0;
            b_reg       <= '0;
            count       <= '0;
            alu_out     <= '0;
            res_hi      <= '0;
            carry_out   <= 1'b0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        hi_reg <= '0;
                        lo_reg <= a;
                        b_reg  <= b;
                        count  <= '0;
                        if (state_next == S_DONE) begin
                            alu_out     <= fast_lo;
                            res_hi      <= fast_hi;
                            carry_out   <= fast_c;
                            zero        <= (fast_lo == '0);
                            overflow    <= fast_ov;
                            div_by_zero <= fast_dz;
                        end
                    end
                end
                S_MUL: begin
                    hi_reg <= mul_hi_next;
                    lo_reg <= mul_lo_next;
                    count  <= count + CNT_W'(1);
                    if (step_last) begin
                        alu_out     <= mul_lo_next;
                        res_hi      <= mul_hi_next;
                        carry_out   <= |mul_hi_next;
                        zero        <= (mul_lo_next == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                S_DIV: begin
                    hi_reg <= div_hi_next;
                    lo_reg <= div_lo_next;
                    count  <= count + CNT_W'(1);
                    if (step_last) begin
                        alu_out     <= div_lo_next;
                        res_hi      <= div_hi_next;
                        carry_out   <= 1'b0;
                        zero        <= (div_lo_next == '0);
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;                        // DONE: hold everything
            endcase
        end
    end

endmodule
